// File: rtl/crc_axi_mst.sv
// AXI3 master for the CRC engine: a read engine streams source words to the
// datapath while a write engine stores the echoed words plus the CRC word.
module crc_axi_mst #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         MAX_BURST  = 16,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   addr_src,
  input  logic [ADDR_WIDTH-1:0]   addr_dst,
  input  logic [15:0]             data_len,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    rd_last,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arid,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awid,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [3:0]              wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t r_rd_state, w_rd_state_nxt;
  wr_state_t r_wr_state, w_wr_state_nxt;

  logic                  r_busy, r_done, r_error;
  logic [ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [15:0]           r_rd_rem, r_wr_rem;
  logic [3:0]            r_arlen, r_awlen, r_rd_beat, r_wr_beat;

  logic                  w_start_acc, w_r_hs, w_r_end, w_w_hs, w_w_end, w_b_hs;
  logic [16:0]           w_nr_full;
  logic [15:0]           w_nr, w_rd_rem_dec;
  logic [ADDR_WIDTH-1:0] w_src_al, w_dst_al, w_rd_addr_inc;
  logic                  w_unused;

  // Beats allowed in the next burst; the 4KB room term keeps bursts inside a page.
  function automatic logic [4:0] f_beats(input logic [11:0] a, input logic [15:0] rem);
    logic [15:0] room, b;
    room = (16'd4096 - {4'd0, a}) >> 2;
    b    = 16'(MAX_BURST);
    if (rem < b)  b = rem;
    if (room < b) b = room;
    return b[4:0];
  endfunction

  assign w_start_acc   = start & ~r_busy;
  assign w_nr_full     = {1'b0, data_len} + 17'd3;
  assign w_nr          = {1'b0, w_nr_full[16:2]};
  assign w_src_al      = {addr_src[ADDR_WIDTH-1:2], 2'b00};
  assign w_dst_al      = {addr_dst[ADDR_WIDTH-1:2], 2'b00};
  assign w_r_hs        = (r_rd_state == R_DATA) & rvalid & rd_ready;
  assign w_r_end       = w_r_hs & (r_rd_beat == r_arlen);
  assign w_rd_addr_inc = r_rd_addr + ADDR_WIDTH'(4);
  assign w_rd_rem_dec  = r_rd_rem - 16'd1;
  assign w_w_hs        = (r_wr_state == W_DATA) & wr_valid & wready;
  assign w_w_end       = w_w_hs & (r_wr_beat == r_awlen);
  assign w_b_hs        = (r_wr_state == W_RESP) & bvalid;
  assign w_unused      = ^{rid, bid, addr_src[1:0], addr_dst[1:0]};

  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign araddr  = r_rd_addr;
  assign arlen   = r_arlen;
  assign awaddr  = r_wr_addr;
  assign awlen   = r_awlen;
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = '0;
  assign awlock  = '0;
  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign wstrb   = '1;

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    arvalid  = 1'b0;
    rready   = 1'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
    rd_last  = 1'b0;
    case (r_rd_state)
      R_IDLE: if (w_start_acc && (w_nr != 16'd0)) w_rd_state_nxt = R_ADDR;
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        rready   = rd_ready;
        rd_valid = rvalid;
        rd_data  = rdata;
        rd_last  = (r_rd_rem == 16'd1);
        if (w_r_end) w_rd_state_nxt = (w_rd_rem_dec != 16'd0) ? R_ADDR : R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wdata    = '0;
    wlast    = 1'b0;
    wr_ready = 1'b0;
    bready   = 1'b0;
    case (r_wr_state)
      W_IDLE: if (w_start_acc && (w_nr != 16'd0)) w_wr_state_nxt = W_ADDR;
      W_ADDR: begin
        awvalid = 1'b1;
        if (awready) w_wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid   = wr_valid;
        wdata    = wr_data;
        wr_ready = wready;
        wlast    = (r_wr_beat == r_awlen);
        if (w_w_end) w_wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_wr_state_nxt = (r_wr_rem != 16'd0) ? W_ADDR : W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Address and remaining count advance per beat, so at a burst end they
  // already describe the next burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_addr  <= '0;
      r_rd_rem   <= '0;
      r_rd_beat  <= '0;
      r_arlen    <= '0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      if (w_start_acc) begin
        r_rd_addr <= w_src_al;
        r_rd_rem  <= w_nr;
        r_rd_beat <= '0;
        if (w_nr != 16'd0) r_arlen <= 4'(f_beats(w_src_al[11:0], w_nr) - 5'd1);
      end else if (w_r_hs) begin
        r_rd_addr <= w_rd_addr_inc;
        r_rd_rem  <= w_rd_rem_dec;
        if (w_r_end) begin
          r_rd_beat <= '0;
          if (w_rd_rem_dec != 16'd0)
            r_arlen <= 4'(f_beats(w_rd_addr_inc[11:0], w_rd_rem_dec) - 5'd1);
        end else begin
          r_rd_beat <= r_rd_beat + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_addr  <= '0;
      r_wr_rem   <= '0;
      r_wr_beat  <= '0;
      r_awlen    <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      if (w_start_acc) begin
        r_wr_addr <= w_dst_al;
        r_wr_rem  <= w_nr + 16'd1;
        r_wr_beat <= '0;
        if (w_nr != 16'd0) r_awlen <= 4'(f_beats(w_dst_al[11:0], w_nr + 16'd1) - 5'd1);
      end else if (w_w_hs) begin
        r_wr_addr <= r_wr_addr + ADDR_WIDTH'(4);
        r_wr_rem  <= r_wr_rem - 16'd1;
        r_wr_beat <= w_w_end ? 4'd0 : r_wr_beat + 4'd1;
      end else if (w_b_hs && (r_wr_rem != 16'd0)) begin
        r_awlen <= 4'(f_beats(r_wr_addr[11:0], r_wr_rem) - 5'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else if (w_start_acc) begin
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy && (r_rd_state == R_IDLE) && (r_wr_state == W_IDLE)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_r_hs && ((rresp != 2'b00) || (rlast != (r_rd_beat == r_arlen)))) r_error <= 1'b1;
      if (w_b_hs && (bresp != 2'b00)) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_crc_axi_mst.sv
// Bench for crc_axi_mst: behavioural AXI slave plus datapath stub, checked
// against burst lists and memory contents derived from the transfer rules.
module tb_crc_axi_mst;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] addr_src, addr_dst;
  logic [15:0] data_len;
  logic        busy, done, error;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arlen, awlen, arid, awid, wid, rid, bid;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [31:0] rdata, wdata;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  crc_axi_mst #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(MAXB), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_src(addr_src), .addr_dst(addr_dst),
    .data_len(data_len), .busy(busy), .done(done), .error(error),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arid(arid), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awid(awid), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] srcword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Observations and slave configuration
  logic [31:0] ar_addr_q[$], aw_addr_q[$], rd_words_q[$], eb_addr[$];
  int          ar_len_q[$], aw_len_q[$], rd_last_pos_q[$], eb_len[$];
  logic [31:0] dmem [logic [31:0]];
  int          viol, wr_sent, cur_nr, rburst, b_cnt, stall_left;
  logic [31:0] cur_crc;
  bit          cfg_rnd, cfg_berr, cfg_rerr, cfg_stall, stalled_once;

  bit          r_open, w_open, b_pend;
  logic [31:0] r_a, w_a, cap_araddr, cap_awaddr;
  int          r_left, w_left, cap_arlen, cap_awlen;
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_hs, wr_hs;

  task automatic slave_idle();
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    bvalid = 0; bresp = 0; bid = 0;
    rd_ready = 0; wr_valid = 0; wr_data = 0;
    r_open = 0; w_open = 0; b_pend = 0; stall_left = 0;
  endtask

  // AXI slave and datapath stub: handshakes sampled mid-cycle, drives updated after the edge.
  initial begin
    slave_idle();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_idle();
        continue;
      end
      ar_hs = arvalid & arready; r_hs = rvalid & rready; aw_hs = awvalid & awready;
      w_hs = wvalid & wready; b_hs = bvalid & bready;
      rd_hs = rd_valid & rd_ready; wr_hs = wr_valid & wr_ready;
      if (wvalid && !w_open) viol++;
      if (rready && !rd_ready) viol++;
      if (ar_hs) begin
        cap_araddr = araddr; cap_arlen = int'(arlen);
        ar_addr_q.push_back(araddr); ar_len_q.push_back(int'(arlen));
      end
      if (aw_hs) begin
        cap_awaddr = awaddr; cap_awlen = int'(awlen);
        aw_addr_q.push_back(awaddr); aw_len_q.push_back(int'(awlen));
      end
      if (rd_hs) begin
        rd_words_q.push_back(rd_data);
        if (rd_last) rd_last_pos_q.push_back(rd_words_q.size());
      end
      if (w_hs) begin
        dmem[w_a] = wdata;
        if (wlast !== (w_left == 1)) viol++;
      end
      @(posedge clk); #1;
      if (ar_hs) begin r_open = 1; r_a = cap_araddr; r_left = cap_arlen + 1; end
      if (r_hs) begin
        r_a += 4; r_left--;
        if (r_left == 0) begin r_open = 0; rburst++; end
      end
      if (aw_hs) begin w_open = 1; w_a = cap_awaddr; w_left = cap_awlen + 1; end
      if (w_hs) begin
        w_a += 4; w_left--;
        if (w_left == 0) begin w_open = 0; b_pend = 1; end
      end
      if (b_hs) begin b_pend = 0; b_cnt++; end
      if (wr_hs) wr_sent++;
      if (stall_left > 0) stall_left--;
      else if (rd_hs && cfg_stall && !stalled_once) begin stall_left = 5; stalled_once = 1; end

      arready = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      awready = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready = (stall_left > 0) ? 1'b0 : (cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (r_open && ((rvalid && !r_hs) || !cfg_rnd || $urandom_range(0, 3) != 0)) begin
        rvalid = 1; rdata = srcword(r_a); rlast = (r_left == 1);
        rresp = (cfg_rerr && rburst == 0 && r_left == 1) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 0; rdata = 0; rlast = 0; rresp = 0;
      end
      if (b_pend && (bvalid || !cfg_rnd || $urandom_range(0, 2) == 0)) begin
        bvalid = 1; bresp = (cfg_berr && b_cnt == 0) ? 2'b10 : 2'b00;
      end else begin
        bvalid = 0; bresp = 0;
      end
      if (!(wr_valid && !wr_hs)) begin
        wr_valid = 0;
        if (wr_sent < cur_nr && wr_sent < rd_words_q.size()) begin
          wr_data = rd_words_q[wr_sent];
          wr_valid = !cfg_rnd || $urandom_range(0, 3) != 0;
        end else if (cur_nr != 0 && wr_sent == cur_nr && rd_words_q.size() == cur_nr) begin
          wr_data = cur_crc;
          wr_valid = !cfg_rnd || $urandom_range(0, 3) != 0;
        end
      end
    end
  end

  // Burst list implied by the page-safe burst rule.
  function automatic void build_bursts(input logic [31:0] a0, input int n);
    logic [31:0] a;
    int rem, room, b;
    eb_addr.delete(); eb_len.delete();
    a = a0 & ~32'd3;
    rem = n;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 4;
      b = MAXB;
      if (rem < b) b = rem;
      if (room < b) b = room;
      eb_addr.push_back(a); eb_len.push_back(b - 1);
      a += 32'(4 * b);
      rem -= b;
    end
  endfunction

  task automatic prep(input logic [31:0] src, input int len, input bit rnd, berr, rerr, stall);
    logic [31:0] s;
    ar_addr_q.delete(); aw_addr_q.delete(); ar_len_q.delete(); aw_len_q.delete();
    rd_words_q.delete(); rd_last_pos_q.delete(); dmem.delete();
    viol = 0; wr_sent = 0; rburst = 0; b_cnt = 0; stalled_once = 0;
    cfg_rnd = rnd; cfg_berr = berr; cfg_rerr = rerr; cfg_stall = stall;
    cur_nr = (len + 3) / 4;
    s = src & ~32'd3;
    cur_crc = 32'hC5C50000 ^ 32'(len);
    for (int i = 0; i < cur_nr; i++) cur_crc ^= srcword(s + 32'(4 * i));
  endtask

  task automatic run(input logic [31:0] src, dst, input int len,
                     input bit rnd, berr, rerr, stall, poke);
    int cyc;
    bit got_done;
    logic [31:0] s, d, k;
    prep(src, len, rnd, berr, rerr, stall);
    s = src & ~32'd3;
    d = dst & ~32'd3;
    @(posedge clk); #2;
    start = 1; addr_src = src; addr_dst = dst; data_len = 16'(len);
    @(posedge clk); #2;
    start = 0; addr_src = $urandom; addr_dst = $urandom; data_len = 16'($urandom);
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", error, 0);
    cyc = 0; got_done = 0;
    while (!got_done && cyc < 20000) begin
      if (poke && cyc == 3) begin start = 1; data_len = 16'd40; end
      @(posedge clk); #2;
      cyc++;
      start = 0;
      if (done) got_done = 1;
    end
    chk("done_seen", got_done, 1);
    if (len == 0) chk("done_latency_len0", cyc, 1);
    chk("busy_drop_with_done", busy, 0);
    chk("error_final", error, berr | rerr);
    @(posedge clk); #2;
    chk("done_single_pulse", done, 0);

    build_bursts(s, cur_nr);
    chk("ar_count", ar_addr_q.size(), eb_addr.size());
    for (int i = 0; i < eb_addr.size() && i < ar_addr_q.size(); i++) begin
      chk("araddr", ar_addr_q[i], eb_addr[i]);
      chk("arlen", ar_len_q[i], eb_len[i]);
    end
    build_bursts(d, (cur_nr == 0) ? 0 : cur_nr + 1);
    chk("aw_count", aw_addr_q.size(), eb_addr.size());
    for (int i = 0; i < eb_addr.size() && i < aw_addr_q.size(); i++) begin
      chk("awaddr", aw_addr_q[i], eb_addr[i]);
      chk("awlen", aw_len_q[i], eb_len[i]);
    end
    chk("rd_word_count", rd_words_q.size(), cur_nr);
    for (int i = 0; i < cur_nr && i < rd_words_q.size(); i++)
      chk("rd_word", rd_words_q[i], srcword(s + 32'(4 * i)));
    chk("rd_last_count", rd_last_pos_q.size(), (cur_nr > 0) ? 1 : 0);
    if (rd_last_pos_q.size() > 0) chk("rd_last_pos", rd_last_pos_q[0], cur_nr);
    chk("wr_word_count", dmem.size(), (cur_nr == 0) ? 0 : cur_nr + 1);
    for (int i = 0; i < cur_nr; i++) begin
      k = d + 32'(4 * i);
      chk("wr_word", dmem.exists(k) ? dmem[k] : ~srcword(s + 32'(4 * i)), srcword(s + 32'(4 * i)));
    end
    if (cur_nr > 0) begin
      k = d + 32'(4 * cur_nr);
      chk("wr_crc_word", dmem.exists(k) ? dmem[k] : ~cur_crc, cur_crc);
    end
    chk("protocol_violations", viol, 0);
  endtask

  initial begin
    int cyc;
    logic [31:0] src, dst;
    rst = 1; start = 0; addr_src = 0; addr_dst = 0; data_len = 0;
    cfg_rnd = 0; cfg_berr = 0; cfg_rerr = 0; cfg_stall = 0; cur_nr = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_awlen", awlen, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_consts", {arsize, awsize, arburst, awburst, arlock, awlock, wstrb, arid, awid, wid},
        {3'b010, 3'b010, 2'b01, 2'b01, 2'b00, 2'b00, 4'hF, 4'h0, 4'h0, 4'h0});
    #1 rst = 0;

    run(32'h100, 32'h200, 0, 0, 0, 0, 0, 0);
    run(32'h100, 32'h200, 10, 0, 0, 0, 0, 0);
    chk("tp10_ar0", {ar_addr_q[0], 32'(ar_len_q[0])}, {32'h100, 32'd2});
    chk("tp10_aw0", {aw_addr_q[0], 32'(aw_len_q[0])}, {32'h200, 32'd3});
    run(32'h100, 32'h200, 128, 0, 0, 0, 0, 1);
    chk("tp128_ar1", {ar_addr_q[1], 32'(ar_len_q[1])}, {32'h140, 32'd15});
    chk("tp128_aw2", {aw_addr_q[2], 32'(aw_len_q[2])}, {32'h280, 32'd0});
    run(32'hFF8, 32'h2000, 32, 0, 0, 0, 0, 0);
    chk("tp4k_ar0", {ar_addr_q[0], 32'(ar_len_q[0])}, {32'hFF8, 32'd1});
    chk("tp4k_ar1", {ar_addr_q[1], 32'(ar_len_q[1])}, {32'h1000, 32'd5});
    run(32'h100, 32'h200, 128, 0, 1, 0, 1, 0);
    run(32'h3F0, 32'hFC4, 77, 1, 0, 1, 0, 0);

    // Reset in the middle of a run, then a clean transfer.
    prep(32'h100, 128, 0, 0, 0, 0);
    @(posedge clk); #2;
    start = 1; addr_src = 32'h100; addr_dst = 32'h300; data_len = 16'd128;
    @(posedge clk); #2;
    start = 0;
    cyc = 0;
    while (!(arvalid && ar_addr_q.size() >= 1) && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("rst_mid_arvalid_seen", arvalid, 1);
    #1 rst = 1;
    #1;
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (3) @(posedge clk);
    #3 rst = 0;
    run(32'h100, 32'h300, 128, 0, 0, 0, 0, 0);

    for (int t = 0; t < 14; t++) begin
      src = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 16383))
                                        : 32'h1000 * $urandom_range(1, 3) - 32'($urandom_range(1, 40));
      dst = 32'h10000 + 32'($urandom_range(0, 16383));
      run(src, dst, $urandom_range(0, 260), 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
